// File: rtl/riscv_v_pkg.sv
// Shared vector-unit types: VLEN, mask register/address types and the mask-reader state.
package riscv_v_pkg;
  localparam int VLEN          = 128;
  localparam int NUM_MASK_REGS = 32;

  typedef logic [VLEN-1:0] riscv_v_mask_reg_t;
  typedef logic [4:0]      riscv_v_mask_rf_addr_t;

  typedef enum logic [1:0] {
    MRD_IDLE    = 2'd0,
    MRD_RD_WAIT = 2'd1,
    MRD_STREAM  = 2'd2
  } riscv_v_mask_rd_state_e;
endpackage

// File: rtl/riscv_v_mask_rf.sv
// Mask register file: one write port and one read port, read either combinational or registered.
module riscv_v_mask_rf
  import riscv_v_pkg::*;
#(
  parameter logic RD_ASYNC = 1'b1
) (
  input  logic                  clk,
  input  logic                  we,
  input  riscv_v_mask_rf_addr_t waddr,
  input  riscv_v_mask_reg_t     wdata,
  input  riscv_v_mask_rf_addr_t rd_addr,
  output riscv_v_mask_reg_t     rd_data
);
  riscv_v_mask_reg_t mem [NUM_MASK_REGS];
  riscv_v_mask_reg_t rd_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_q <= mem[rd_addr];
  end

  assign rd_data = RD_ASYNC ? mem[rd_addr] : rd_q;
endmodule

// File: rtl/riscv_v_mask_reader.sv
// Reads one mask register and streams it out in ELEMS_PER_BEAT-bit beats with tail zeroing.
module riscv_v_mask_reader
  import riscv_v_pkg::*;
#(
  parameter logic RD_ASYNC       = 1'b1,
  parameter int   ELEMS_PER_BEAT = 8,
  localparam int  VL_W           = $clog2(VLEN) + 1,
  localparam int  IDX_W          = $clog2(VLEN / ELEMS_PER_BEAT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  riscv_v_mask_rf_addr_t     req_addr,
  input  logic [VL_W-1:0]           req_vl,
  input  logic                      req_vm,
  output riscv_v_mask_rf_addr_t     rf_rd_addr,
  input  riscv_v_mask_reg_t         rf_rd_data,
  output logic                      beat_valid,
  input  logic                      beat_ready,
  output logic [ELEMS_PER_BEAT-1:0] beat_mask,
  output logic [IDX_W-1:0]          beat_idx,
  output logic                      beat_last
);
  riscv_v_mask_rd_state_e state_q, state_d;
  riscv_v_mask_rf_addr_t  addr_q, addr_d;
  riscv_v_mask_reg_t      mask_q, mask_d;
  logic [VL_W-1:0]        vl_q, vl_d, vl_eff;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   vm_q, vm_d;
  logic                   is_last;

  // One bit per element of beat idx: set while the element index is below vl.
  function automatic logic [ELEMS_PER_BEAT-1:0] tail_mask(input logic [IDX_W-1:0] idx,
                                                          input logic [VL_W-1:0]  vl);
    logic [ELEMS_PER_BEAT-1:0] m;
    int base;
    base = int'(idx) * ELEMS_PER_BEAT;
    for (int i = 0; i < ELEMS_PER_BEAT; i++) m[i] = (base + i) < int'(vl);
    return m;
  endfunction

  assign vl_eff  = (req_vl > VL_W'(VLEN)) ? VL_W'(VLEN) : req_vl;
  assign is_last = ((int'(idx_q) + 1) * ELEMS_PER_BEAT) >= int'(vl_q);
  assign beat_idx = idx_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mask_d     = mask_q;
    vl_d       = vl_q;
    idx_d      = idx_q;
    vm_d       = vm_q;
    req_ready  = 1'b0;
    beat_valid = 1'b0;
    beat_last  = 1'b0;
    beat_mask  = '0;
    rf_rd_addr = addr_q;
    case (state_q)
      MRD_IDLE: begin
        req_ready  = 1'b1;
        rf_rd_addr = req_addr;
        if (req_valid) begin
          addr_d = req_addr;
          vm_d   = req_vm;
          vl_d   = vl_eff;
          idx_d  = '0;
          if (vl_eff == '0) begin
            state_d = MRD_IDLE;
          end else if (RD_ASYNC || req_vm) begin
            mask_d  = req_vm ? '1 : rf_rd_data;
            state_d = MRD_STREAM;
          end else begin
            state_d = MRD_RD_WAIT;
          end
        end
      end
      MRD_RD_WAIT: begin
        // Registered RF presents the data of the address latched at accept.
        mask_d  = vm_q ? '1 : rf_rd_data;
        state_d = MRD_STREAM;
      end
      MRD_STREAM: begin
        beat_valid = 1'b1;
        beat_last  = is_last;
        beat_mask  = mask_q[idx_q*ELEMS_PER_BEAT +: ELEMS_PER_BEAT] & tail_mask(idx_q, vl_q);
        if (beat_ready) begin
          if (is_last) begin
            state_d = MRD_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = MRD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MRD_IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
      vl_q    <= '0;
      idx_q   <= '0;
      vm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      vl_q    <= vl_d;
      idx_q   <= idx_d;
      vm_q    <= vm_d;
    end
  end
endmodule

// File: tb/tb_riscv_v_mask_reader.sv
// Bench for riscv_v_mask_reader: one combinational-RF and one registered-RF instance, scoreboard-checked.
module tb_riscv_v_mask_reader;
  import riscv_v_pkg::*;

  typedef struct packed {
    logic [7:0] m;
    logic [3:0] idx;
    logic       last;
  } exp_t;

  logic clk, rst_n;
  logic req_valid_a, req_valid_s, req_vm, beat_ready, sel;
  riscv_v_mask_rf_addr_t req_addr, wr_addr, rd_addr_a, rd_addr_s;
  riscv_v_mask_reg_t wr_data, rd_data_a, rd_data_s;
  logic we;
  logic [7:0] req_vl;
  logic rr_a, rr_s, bv_a, bv_s, bl_a, bl_s;
  logic [7:0] bm_a, bm_s;
  logic [3:0] bi_a, bi_s;
  logic rr, bv, bl;
  logic [7:0] bm;
  logic [3:0] bi;

  riscv_v_mask_reg_t rf_model [32];
  exp_t sb [$];
  int n_cmp = 0;
  int n_err = 0;

  riscv_v_mask_rf #(.RD_ASYNC(1'b1)) u_rf_a (.clk(clk), .we(we), .waddr(wr_addr), .wdata(wr_data),
                                             .rd_addr(rd_addr_a), .rd_data(rd_data_a));
  riscv_v_mask_rf #(.RD_ASYNC(1'b0)) u_rf_s (.clk(clk), .we(we), .waddr(wr_addr), .wdata(wr_data),
                                             .rd_addr(rd_addr_s), .rd_data(rd_data_s));

  riscv_v_mask_reader #(.RD_ASYNC(1'b1), .ELEMS_PER_BEAT(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_ready(rr_a), .req_addr(req_addr),
    .req_vl(req_vl), .req_vm(req_vm), .rf_rd_addr(rd_addr_a), .rf_rd_data(rd_data_a),
    .beat_valid(bv_a), .beat_ready(beat_ready), .beat_mask(bm_a), .beat_idx(bi_a), .beat_last(bl_a));

  riscv_v_mask_reader #(.RD_ASYNC(1'b0), .ELEMS_PER_BEAT(8)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_s), .req_ready(rr_s), .req_addr(req_addr),
    .req_vl(req_vl), .req_vm(req_vm), .rf_rd_addr(rd_addr_s), .rf_rd_data(rd_data_s),
    .beat_valid(bv_s), .beat_ready(beat_ready), .beat_mask(bm_s), .beat_idx(bi_s), .beat_last(bl_s));

  assign rr = sel ? rr_s : rr_a;
  assign bv = sel ? bv_s : bv_a;
  assign bl = sel ? bl_s : bl_a;
  assign bm = sel ? bm_s : bm_a;
  assign bi = sel ? bi_s : bi_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic write_rf(input logic [4:0] a, input riscv_v_mask_reg_t d);
    we = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    we = 1'b0;
    rf_model[a] = d;
  endtask

  task automatic do_req(input bit s, input logic [4:0] addr, input int vl, input bit vm,
                        input int stall0, input int exp_lat, input string name);
    int vl_eff, nb, cyc, guard, stall;
    bit first;
    exp_t e;
    vl_eff = (vl > VLEN) ? VLEN : vl;
    nb = (vl_eff + 7) / 8;
    for (int k = 0; k < nb; k++) begin
      e.m = vm ? 8'hFF : rf_model[addr][k*8 +: 8];
      for (int i = 0; i < 8; i++) if (k*8 + i >= vl_eff) e.m[i] = 1'b0;
      e.idx  = 4'(k);
      e.last = (k == nb - 1);
      sb.push_back(e);
    end
    sel = s; req_addr = addr; req_vl = 8'(vl); req_vm = vm; beat_ready = 1'b1;
    if (s) req_valid_s = 1'b1; else req_valid_a = 1'b1;
    #1;
    n_cmp++;
    if (rr !== 1'b1) begin n_err++; $display("FAIL %s req_ready at accept: got %b want 1", name, rr); end
    n_cmp++;
    if (bv !== 1'b0) begin n_err++; $display("FAIL %s beat_valid on accept cycle: got %b want 0", name, bv); end
    @(posedge clk); #1;
    req_valid_a = 1'b0; req_valid_s = 1'b0;
    cyc = 1; first = 1'b1; stall = stall0; guard = 0;
    if (nb == 0) begin
      n_cmp++;
      if (rr !== 1'b1 || bv !== 1'b0) begin
        n_err++; $display("FAIL %s vl0 next cycle: ready=%b valid=%b want 1/0", name, rr, bv);
      end
    end
    while (sb.size() > 0 && guard < 300) begin
      if (bv) begin
        if (first) begin
          n_cmp++;
          if (cyc != exp_lat) begin n_err++; $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat); end
          first = 1'b0;
        end
        n_cmp++;
        if ({bm, bi, bl} !== {sb[0].m, sb[0].idx, sb[0].last}) begin
          n_err++;
          $display("FAIL %s beat: got mask=%h idx=%0d last=%b want mask=%h idx=%0d last=%b",
                   name, bm, bi, bl, sb[0].m, sb[0].idx, sb[0].last);
        end
        if (stall > 0) begin
          beat_ready = 1'b0; stall--;
        end else begin
          beat_ready = 1'b1; void'(sb.pop_front());
        end
      end
      @(posedge clk); #1;
      cyc++; guard++;
    end
    if (guard >= 300) begin
      n_cmp++; n_err++;
      $display("FAIL %s timeout: %0d beats still expected", name, sb.size());
      sb.delete();
    end else if (nb > 0) begin
      n_cmp++;
      if (rr !== 1'b1 || bv !== 1'b0) begin
        n_err++; $display("FAIL %s after last: ready=%b valid=%b want 1/0", name, rr, bv);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid_a = 1'b0; req_valid_s = 1'b0; beat_ready = 1'b0; sel = 1'b0;
    req_addr = '0; req_vl = '0; req_vm = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bv_a, bl_a, bm_a, bi_a} !== 14'd0) begin
      n_err++; $display("FAIL reset_async outputs: got %b%b %h %0d want all 0", bv_a, bl_a, bm_a, bi_a);
    end
    n_cmp++;
    if ({bv_s, bl_s, bm_s, bi_s} !== 14'd0) begin
      n_err++; $display("FAIL reset_sync outputs: got %b%b %h %0d want all 0", bv_s, bl_s, bm_s, bi_s);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (rr_a !== 1'b1 || rr_s !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b/%b want 1/1", rr_a, rr_s);
    end
  endtask

  task automatic test_basic();
    do_req(1'b0, 5'd3, 16, 1'b0, 0, 1, "async_vl16");
    do_req(1'b0, 5'd3, 13, 1'b0, 0, 1, "async_vl13_tail");
  endtask

  task automatic test_unmasked();
    do_req(1'b0, 5'd3, 20, 1'b1, 0, 1, "async_vm_vl20");
    do_req(1'b1, 5'd3, 20, 1'b1, 0, 1, "sync_vm_vl20");
  endtask

  task automatic test_boundaries();
    do_req(1'b0, 5'd3, 0, 1'b0, 0, 1, "async_vl0");
    do_req(1'b1, 5'd3, 0, 1'b0, 0, 1, "sync_vl0");
    do_req(1'b0, 5'd7, 200, 1'b0, 0, 1, "async_vl200_clamp");
    do_req(1'b0, 5'd7, 128, 1'b0, 0, 1, "async_vl128");
  endtask

  task automatic test_sync_stall();
    do_req(1'b1, 5'd3, 16, 1'b0, 3, 2, "sync_vl16_stall");
    do_req(1'b1, 5'd7, 37, 1'b0, 1, 2, "sync_vl37");
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 10; t++) begin
      bit s, vm;
      logic [4:0] a;
      s  = 1'($urandom_range(0, 1));
      vm = ($urandom_range(0, 3) == 0);
      a  = ($urandom_range(0, 1) == 0) ? 5'd3 : 5'd7;
      do_req(s, a, int'($urandom_range(0, 150)), vm, int'($urandom_range(0, 2)),
             (s && !vm) ? 2 : 1, "back_to_back");
    end
  endtask

  task automatic test_reset_mid_stream();
    sel = 1'b0; req_addr = 5'd7; req_vl = 8'd32; req_vm = 1'b0; beat_ready = 1'b1;
    req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (bv !== 1'b1 || bi !== 4'd1) begin
      n_err++; $display("FAIL midrst beat1 present: valid=%b idx=%0d want 1/1", bv, bi);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bv, bl, bm, bi} !== 14'd0) begin
      n_err++; $display("FAIL midrst outputs: got %b%b %h %0d want all 0", bv, bl, bm, bi);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (rr !== 1'b1 || bv !== 1'b0) begin
      n_err++; $display("FAIL midrst release: ready=%b valid=%b want 1/0", rr, bv);
    end
    @(posedge clk); #1;
    do_req(1'b0, 5'd7, 32, 1'b0, 0, 1, "after_reset");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
    test_reset();
    write_rf(5'd3, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3CA5);
    write_rf(5'd7, 128'hF0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F);
    test_basic();
    test_unmasked();
    test_boundaries();
    test_sync_stall();
    test_back_to_back();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
